// File: rtl/hazard_controller_if.sv
//------------------------------------------------------------------------------
// Module  : hazard_controller_if
// Brief   : Datapath <-> hazard controller signal bundle (hazard inputs,
//           pipeline enables/flushes, forwarding selects, stall counter).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface hazard_controller_if;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;
    logic        RegWriteE;
    logic [2:0]  ResultSrcE;
    logic        MduE;
    logic        PCSrcE;
    logic [4:0]  RdM;
    logic [4:0]  RdW;
    logic        RegWriteM;
    logic        RegWriteW;
    logic        enF;
    logic        enFD;
    logic        enDE;
    logic        enEM;
    logic        flushFD;
    logic        flushDE;
    logic        flushEM;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic [31:0] stall_count;

    // Datapath side
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, MduE, PCSrcE,
               RdM, RdW, RegWriteM, RegWriteW,
        input  enF, enFD, enDE, enEM, flushFD, flushDE, flushEM,
               ForwardAE, ForwardBE, stall_count
    );

    // Controller side
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, MduE, PCSrcE,
               RdM, RdW, RegWriteM, RegWriteW,
        output enF, enFD, enDE, enEM, flushFD, flushDE, flushEM,
               ForwardAE, ForwardBE, stall_count
    );
endinterface

`default_nettype wire

// File: rtl/hazard_controller.sv
//------------------------------------------------------------------------------
// Module  : hazard_controller
// Brief   : Load-use stall, branch flush, MDU hold FSM and EX forwarding for a
//           five-stage pipeline, plus a stalled-fetch cycle counter.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_controller #(
    parameter int          MDU_LATENCY = 4,
    parameter logic [2:0]  LOAD_SRC    = 3'b001
) (
    input  wire logic          clk,
    input  wire logic          reset,
    hazard_controller_if.slave bus
);

    localparam int                 c_CNT_W    = $clog2(MDU_LATENCY);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MDU_LATENCY - 1);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_stall_count;

    logic w_lw_stall;
    logic w_mdu_hold;
    logic w_enF, w_enFD, w_enDE, w_enEM;
    logic w_flushFD, w_flushDE, w_flushEM;
    logic [1:0] w_fwd_a, w_fwd_b;

    // x0 is never a real producer, so it neither forwards nor stalls.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (bus.RegWriteM && (bus.RdM != 5'd0) && (rs == bus.RdM))
            return 2'b10;
        else if (bus.RegWriteW && (bus.RdW != 5'd0) && (rs == bus.RdW))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign w_lw_stall = (bus.ResultSrcE == LOAD_SRC) && bus.RegWriteE &&
                        (bus.RdE != 5'd0) &&
                        ((bus.Rs1D == bus.RdE) || (bus.Rs2D == bus.RdE));

    assign w_mdu_hold = ((r_state == RUN) && bus.MduE) ||
                        ((r_state == MDU_BUSY) && (r_cnt != c_CNT_LAST));

    always_comb begin
        w_enF     = 1'b1;
        w_enFD    = 1'b1;
        w_enDE    = 1'b1;
        w_enEM    = 1'b1;
        w_flushFD = 1'b0;
        w_flushDE = 1'b0;
        w_flushEM = 1'b0;
        w_fwd_a   = 2'b00;
        w_fwd_b   = 2'b00;
        if (reset) begin
            w_fwd_a = fwd_sel(bus.Rs1E);
            w_fwd_b = fwd_sel(bus.Rs2E);
            // The MDU op itself must never be flushed, so the hold outranks a branch.
            if (w_mdu_hold) begin
                w_enF     = 1'b0;
                w_enFD    = 1'b0;
                w_enDE    = 1'b0;
                w_flushEM = 1'b1;
            end else if (bus.PCSrcE) begin
                w_flushFD = 1'b1;
                w_flushDE = 1'b1;
            end else if (w_lw_stall) begin
                w_enF     = 1'b0;
                w_enFD    = 1'b0;
                w_flushDE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= RUN;
            r_cnt         <= '0;
            r_stall_count <= '0;
        end else begin
            if (!w_enF)
                r_stall_count <= r_stall_count + 32'd1;
            case (r_state)
                RUN: begin
                    if (bus.MduE) begin
                        r_state <= MDU_BUSY;
                        r_cnt   <= c_CNT_W'(1);
                    end
                end
                MDU_BUSY: begin
                    // The last count is the release cycle; MduE is ignored here.
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.enF         = w_enF;
    assign bus.enFD        = w_enFD;
    assign bus.enDE        = w_enDE;
    assign bus.enEM        = w_enEM;
    assign bus.flushFD     = w_flushFD;
    assign bus.flushDE     = w_flushDE;
    assign bus.flushEM     = w_flushEM;
    assign bus.ForwardAE   = w_fwd_a;
    assign bus.ForwardBE   = w_fwd_b;
    assign bus.stall_count = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_hazard_controller.sv
//------------------------------------------------------------------------------
// Module  : tb_hazard_controller
// Brief   : Self-checking bench for hazard_controller against a rule-level model.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_controller;

    localparam int         c_LAT  = 4;
    localparam logic [2:0] c_LOAD = 3'b001;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    // Model state: age of the MDU op in EX (-1 = none in progress), stalled-fetch count.
    int          m_age;
    logic [31:0] m_stalls;

    hazard_controller_if hif ();

    hazard_controller #(
        .MDU_LATENCY (c_LAT),
        .LOAD_SRC    (c_LOAD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] dut_vec();
        return {hif.enF, hif.enFD, hif.enDE, hif.enEM, hif.flushFD, hif.flushDE,
                hif.flushEM, hif.ForwardAE, hif.ForwardBE};
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (hif.RegWriteM && hif.RdM != 0 && rs == hif.RdM) return 2'b10;
        if (hif.RegWriteW && hif.RdW != 0 && rs == hif.RdW) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_holding();
        return (m_age < 0 && hif.MduE) || (m_age >= 1 && m_age < c_LAT - 1);
    endfunction

    // Expected {enF,enFD,enDE,enEM,flushFD,flushDE,flushEM,ForwardAE,ForwardBE}
    function automatic logic [10:0] model_vec();
        logic eF, eFD, eDE, eEM, fFD, fDE, fEM, lw;
        eF = 1; eFD = 1; eDE = 1; eEM = 1; fFD = 0; fDE = 0; fEM = 0;
        if (!reset) return 11'b1111_000_00_00;
        lw = hif.ResultSrcE == c_LOAD && hif.RegWriteE && hif.RdE != 0 &&
             (hif.Rs1D == hif.RdE || hif.Rs2D == hif.RdE);
        if (m_holding()) begin
            eF = 0; eFD = 0; eDE = 0; fEM = 1;
        end else if (hif.PCSrcE) begin
            fFD = 1; fDE = 1;
        end else if (lw) begin
            eF = 0; eFD = 0; fDE = 1;
        end
        return {eF, eFD, eDE, eEM, fFD, fDE, fEM, m_fwd(hif.Rs1E), m_fwd(hif.Rs2E)};
    endfunction

    // Advance the model across one rising edge using the inputs held during the cycle.
    task automatic tick();
        logic stalled;
        logic starting;
        @(posedge clk);
        stalled  = !model_vec()[10];
        starting = (m_age < 0) && hif.MduE;
        if (!reset) begin
            m_age = -1; m_stalls = 0;
        end else begin
            if (stalled) m_stalls = m_stalls + 1;
            if (starting)                m_age = 1;
            else if (m_age == c_LAT - 1) m_age = -1;
            else if (m_age >= 1)         m_age = m_age + 1;
        end
    endtask

    task automatic set_idle();
        hif.Rs1D = 0; hif.Rs2D = 0; hif.Rs1E = 0; hif.Rs2E = 0; hif.RdE = 0;
        hif.RegWriteE = 0; hif.ResultSrcE = 3'b000; hif.MduE = 0; hif.PCSrcE = 0;
        hif.RdM = 0; hif.RdW = 0; hif.RegWriteM = 0; hif.RegWriteW = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 0; m_age = -1; m_stalls = 0;
        set_idle();
        hif.MduE = 1; hif.PCSrcE = 1; hif.RegWriteM = 1; hif.RdM = 3; hif.Rs1E = 3;
        #1;
        checks++;
        if (dut_vec() !== 11'b1111_000_00_00) begin
            errors++; $display("FAIL reset_outputs: got %b want %b", dut_vec(), 11'b1111_000_00_00);
        end
        checks++;
        if (hif.stall_count !== 32'd0) begin
            errors++; $display("FAIL reset_stall_count: got %0d want 0", hif.stall_count);
        end
        tick();
        @(negedge clk);
        set_idle();
        reset = 1;
        #1;
        checks++;
        if (dut_vec() !== 11'b1111_000_00_00) begin
            errors++; $display("FAIL reset_release_idle: got %b want %b", dut_vec(), 11'b1111_000_00_00);
        end
        tick();
    endtask

    task automatic test_load_use();
        logic [31:0] base;
        @(negedge clk);
        base = hif.stall_count;
        set_idle();
        hif.ResultSrcE = 3'b001; hif.RegWriteE = 1; hif.RdE = 5; hif.Rs1D = 5;
        #1;
        checks++;
        if (dut_vec() !== 11'b0011_010_00_00) begin
            errors++; $display("FAIL load_use_stall: got %b want %b", dut_vec(), 11'b0011_010_00_00);
        end
        tick();
        @(negedge clk);
        set_idle();
        hif.ResultSrcE = 3'b001; hif.RegWriteE = 1; hif.RdE = 0; hif.Rs1D = 0;
        #1;
        checks++;
        if (hif.stall_count !== base + 32'd1) begin
            errors++; $display("FAIL load_use_count: got %0d want %0d", hif.stall_count, base + 32'd1);
        end
        checks++;
        if (dut_vec() !== 11'b1111_000_00_00) begin
            errors++; $display("FAIL load_use_x0: got %b want %b", dut_vec(), 11'b1111_000_00_00);
        end
        tick();
    endtask

    task automatic test_branch();
        logic [31:0] base;
        @(negedge clk);
        base = hif.stall_count;
        set_idle();
        hif.PCSrcE = 1; hif.ResultSrcE = 3'b001; hif.RegWriteE = 1; hif.RdE = 9; hif.Rs2D = 9;
        #1;
        checks++;
        if (dut_vec() !== 11'b1111_110_00_00) begin
            errors++; $display("FAIL branch_over_lw: got %b want %b", dut_vec(), 11'b1111_110_00_00);
        end
        tick();
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (hif.stall_count !== base) begin
            errors++; $display("FAIL branch_count: got %0d want %0d", hif.stall_count, base);
        end
        tick();
    endtask

    // Holds MduE high for n cycles and checks the per-cycle hold pattern.
    task automatic test_mdu(input int n, input int holds_expected, input string tag);
        logic [31:0] base;
        int          holds;
        holds = 0;
        @(negedge clk);
        base = hif.stall_count;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            set_idle();
            hif.MduE = 1;
            #1;
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL %s_cycle%0d: got %b want %b", tag, i, dut_vec(), model_vec());
            end
            if (!hif.enDE && hif.flushEM) holds++;
            tick();
        end
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (holds != holds_expected) begin
            errors++; $display("FAIL %s_holds: got %0d want %0d", tag, holds, holds_expected);
        end
        checks++;
        if (hif.stall_count !== base + 32'(holds_expected)) begin
            errors++; $display("FAIL %s_count: got %0d want %0d", tag, hif.stall_count,
                               base + 32'(holds_expected));
        end
        tick();
    endtask

    task automatic test_back_to_back();
        test_mdu(2 * c_LAT, 2 * (c_LAT - 1), "mdu_b2b");
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        set_idle();
        hif.Rs1E = 7; hif.RdM = 7; hif.RdW = 7; hif.RegWriteM = 1; hif.RegWriteW = 1;
        #1;
        checks++;
        if (hif.ForwardAE !== 2'b10) begin
            errors++; $display("FAIL fwd_mem_priority: got %b want 10", hif.ForwardAE);
        end
        hif.RegWriteM = 0;
        #1;
        checks++;
        if (hif.ForwardAE !== 2'b01) begin
            errors++; $display("FAIL fwd_wb: got %b want 01", hif.ForwardAE);
        end
        hif.Rs2E = 0; hif.RdM = 0; hif.RdW = 0; hif.RegWriteM = 1;
        #1;
        checks++;
        if (hif.ForwardBE !== 2'b00) begin
            errors++; $display("FAIL fwd_x0: got %b want 00", hif.ForwardBE);
        end
        hif.Rs2E = 12; hif.RdW = 12; hif.RdM = 4;
        #1;
        checks++;
        if (hif.ForwardBE !== 2'b01 || hif.ForwardAE !== 2'b00) begin
            errors++; $display("FAIL fwd_b_wb: got A=%b B=%b want A=00 B=01", hif.ForwardAE, hif.ForwardBE);
        end
        tick();
    endtask

    task automatic test_reset_mid_hold();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_idle();
            hif.MduE = (i == 0);
            #1;
            checks++;
            if (hif.enF !== 1'b0) begin
                errors++; $display("FAIL midhold_setup%0d: enF got %b want 0", i, hif.enF);
            end
            if (i < 2) tick();
        end
        reset = 0; m_age = -1; m_stalls = 0;
        #1;
        checks++;
        if (hif.enF !== 1'b1 || hif.stall_count !== 32'd0) begin
            errors++; $display("FAIL midhold_abort: got enF=%b count=%0d want enF=1 count=0",
                               hif.enF, hif.stall_count);
        end
        tick();
        @(negedge clk);
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (dut_vec() !== 11'b1111_000_00_00 || hif.stall_count !== 32'd0) begin
                errors++; $display("FAIL midhold_run%0d: got %b count=%0d want 11110000000 count=0",
                                   i, dut_vec(), hif.stall_count);
            end
            tick();
        end
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hif.Rs1D = 5'($urandom_range(0, 3)); hif.Rs2D = 5'($urandom_range(0, 3));
            hif.Rs1E = 5'($urandom_range(0, 3)); hif.Rs2E = 5'($urandom_range(0, 3));
            hif.RdE  = 5'($urandom_range(0, 3)); hif.RdM  = 5'($urandom_range(0, 3));
            hif.RdW  = 5'($urandom_range(0, 3));
            hif.RegWriteE = 1'($urandom); hif.RegWriteM = 1'($urandom); hif.RegWriteW = 1'($urandom);
            hif.ResultSrcE = ($urandom_range(0, 1) == 1) ? c_LOAD : 3'($urandom);
            hif.MduE   = ($urandom_range(0, 7) == 0);
            hif.PCSrcE = ($urandom_range(0, 5) == 0);
            #1;
            checks++;
            if (dut_vec() !== model_vec() || hif.stall_count !== m_stalls) begin
                errors++; $display("FAIL random%0d: got %b count=%0d want %b count=%0d",
                                   i, dut_vec(), hif.stall_count, model_vec(), m_stalls);
            end
            tick();
        end
    endtask

    initial begin
        errors = 0; checks = 0; m_age = -1; m_stalls = 0;
        set_idle();
        reset = 1;
        #2 reset = 0;
        test_reset();
        test_load_use();
        test_branch();
        test_mdu(c_LAT, c_LAT - 1, "mdu");
        test_back_to_back();
        test_forwarding();
        test_reset_mid_hold();
        test_random(400);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
